// File: rtl/spi_bus_arbiter.sv
// Two-requester arbiter in front of a byte-wide SPI master: owns chip selects,
// sequences setup/transfer/gap phases and keeps one byte outstanding at a time.
`timescale 1ns/1ps
module spi_bus_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_GAP   = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_0,
  input  logic       req_1,
  input  logic [4:0] len_0,
  input  logic [4:0] len_1,
  input  logic [7:0] tx_byte_0,
  input  logic [7:0] tx_byte_1,
  input  logic       tx_dv_0,
  input  logic       tx_dv_1,
  output logic       tx_rdy_0,
  output logic       tx_rdy_1,
  output logic       rx_dv_0,
  output logic       rx_dv_1,
  output logic       gnt_0,
  output logic       gnt_1,
  output logic       done_0,
  output logic       done_1,
  output logic [7:0] rx_byte,
  output logic [1:0] cs_n,
  output logic [7:0] m_tx_byte,
  output logic       m_tx_dv,
  input  logic       m_tx_ready,
  input  logic       m_rx_dv,
  input  logic [7:0] m_rx_byte
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, GAP} state_t;

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] GAP_LAST   = 16'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [4:0]  len_q, len_d;
  logic [4:0]  sent_q, sent_d;
  logic [4:0]  rcvd_q, rcvd_d;
  logic        pending_q, pending_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  cs_n_q, cs_n_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  rx_dv_q, rx_dv_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [7:0]  m_tx_byte_q, m_tx_byte_d;
  logic        m_tx_dv_q, m_tx_dv_d;

  logic [1:0]  req_vec;
  logic        grant_sel;
  logic [4:0]  grant_len;
  logic        tx_dv_own;
  logic [7:0]  tx_byte_own;
  logic        xfer_rdy;
  logic        accept;
  logic        rx_take;

  // A requester whose done pulse is on the wire is still holding req for this
  // cycle; masking it stops a zero-length request from being granted twice.
  always_comb begin
    req_vec     = {req_1 & ~done_q[1], req_0 & ~done_q[0]};
    grant_sel   = (req_vec == 2'b11) ? ~last_owner_q : req_vec[1];
    grant_len   = grant_sel ? len_1 : len_0;
    tx_dv_own   = owner_q ? tx_dv_1 : tx_dv_0;
    tx_byte_own = owner_q ? tx_byte_1 : tx_byte_0;
    xfer_rdy    = (state_q == XFER) & m_tx_ready & ~pending_q & (sent_q < len_q);
    accept      = xfer_rdy & tx_dv_own;
    rx_take     = (state_q == XFER) & m_rx_dv;
  end

  assign tx_rdy_0  = xfer_rdy & ~owner_q;
  assign tx_rdy_1  = xfer_rdy & owner_q;
  assign rx_dv_0   = rx_dv_q[0];
  assign rx_dv_1   = rx_dv_q[1];
  assign gnt_0     = gnt_q[0];
  assign gnt_1     = gnt_q[1];
  assign done_0    = done_q[0];
  assign done_1    = done_q[1];
  assign rx_byte   = rx_byte_q;
  assign cs_n      = cs_n_q;
  assign m_tx_byte = m_tx_byte_q;
  assign m_tx_dv   = m_tx_dv_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    len_d        = len_q;
    sent_d       = sent_q;
    rcvd_d       = rcvd_q;
    pending_d    = pending_q;
    cnt_d        = cnt_q;
    gnt_d        = gnt_q;
    cs_n_d       = cs_n_q;
    done_d       = 2'b00;
    rx_dv_d      = 2'b00;
    rx_byte_d    = rx_byte_q;
    m_tx_byte_d  = m_tx_byte_q;
    m_tx_dv_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_vec != 2'b00) begin
          owner_d   = grant_sel;
          len_d     = grant_len;
          sent_d    = 5'd0;
          rcvd_d    = 5'd0;
          pending_d = 1'b0;
          cnt_d     = 16'd0;
          if (grant_len == 5'd0) begin
            done_d[grant_sel] = 1'b1;
            last_owner_d      = grant_sel;
          end else begin
            gnt_d   = grant_sel ? 2'b10 : 2'b01;
            cs_n_d  = grant_sel ? 2'b01 : 2'b10;
            state_d = SETUP;
          end
        end
      end

      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          cnt_d   = 16'd0;
          state_d = XFER;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      XFER: begin
        if (rcvd_q == len_q) begin
          cs_n_d           = 2'b11;
          gnt_d            = 2'b00;
          done_d[owner_q]  = 1'b1;
          last_owner_d     = owner_q;
          cnt_d            = 16'd0;
          state_d          = GAP;
        end else begin
          if (rx_take) begin
            rx_byte_d        = m_rx_byte;
            rx_dv_d[owner_q] = 1'b1;
            rcvd_d           = rcvd_q + 5'd1;
            pending_d        = 1'b0;
          end
          if (accept) begin
            m_tx_byte_d = tx_byte_own;
            m_tx_dv_d   = 1'b1;
            sent_d      = sent_q + 5'd1;
            pending_d   = 1'b1;
          end
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      len_q        <= 5'd0;
      sent_q       <= 5'd0;
      rcvd_q       <= 5'd0;
      pending_q    <= 1'b0;
      cnt_q        <= 16'd0;
      gnt_q        <= 2'b00;
      cs_n_q       <= 2'b11;
      done_q       <= 2'b00;
      rx_dv_q      <= 2'b00;
      rx_byte_q    <= 8'h00;
      m_tx_byte_q  <= 8'h00;
      m_tx_dv_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      len_q        <= len_d;
      sent_q       <= sent_d;
      rcvd_q       <= rcvd_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      gnt_q        <= gnt_d;
      cs_n_q       <= cs_n_d;
      done_q       <= done_d;
      rx_dv_q      <= rx_dv_d;
      rx_byte_q    <= rx_byte_d;
      m_tx_byte_q  <= m_tx_byte_d;
      m_tx_dv_q    <= m_tx_dv_d;
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: stimulus queues expected SPI-master bytes,
// received bytes and done pulses; a monitor pops them as the DUT pulses outputs.
`timescale 1ns/1ps
module tb_spi_bus_arbiter;
  localparam int CS_SETUP = 2;
  localparam int CS_GAP   = 31;
  localparam int TMO      = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_0, req_1;
  logic [4:0] len_0, len_1;
  logic [7:0] tx_byte_0, tx_byte_1;
  logic       tx_dv_0, tx_dv_1;
  logic       tx_rdy_0, tx_rdy_1, rx_dv_0, rx_dv_1;
  logic       gnt_0, gnt_1, done_0, done_1;
  logic [7:0] rx_byte;
  logic [1:0] cs_n;
  logic [7:0] m_tx_byte;
  logic       m_tx_dv;
  logic       m_tx_ready;
  logic       m_rx_dv;
  logic [7:0] m_rx_byte;

  spi_bus_arbiter #(.CS_SETUP(CS_SETUP), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst),
    .req_0(req_0), .req_1(req_1), .len_0(len_0), .len_1(len_1),
    .tx_byte_0(tx_byte_0), .tx_byte_1(tx_byte_1), .tx_dv_0(tx_dv_0), .tx_dv_1(tx_dv_1),
    .tx_rdy_0(tx_rdy_0), .tx_rdy_1(tx_rdy_1), .rx_dv_0(rx_dv_0), .rx_dv_1(rx_dv_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
    .rx_byte(rx_byte), .cs_n(cs_n),
    .m_tx_byte(m_tx_byte), .m_tx_dv(m_tx_dv), .m_tx_ready(m_tx_ready),
    .m_rx_dv(m_rx_dv), .m_rx_byte(m_rx_byte)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] q_mtx[$];
  logic [7:0] q_rx0[$];
  logic [7:0] q_rx1[$];
  logic [7:0] resp_q[$];
  bit         q_done0[$];
  bit         q_done1[$];

  bit mon_en = 1'b0;
  bit cs_low_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles", name, TMO);
  endtask

  function automatic logic rdy_of(input int k);
    return (k == 0) ? tx_rdy_0 : tx_rdy_1;
  endfunction
  function automatic logic gnt_of(input int k);
    return (k == 0) ? gnt_0 : gnt_1;
  endfunction
  function automatic logic done_of(input int k);
    return (k == 0) ? done_0 : done_1;
  endfunction

  // Expected response of one transaction: bytes/resps packed LSB-first.
  task automatic expect_txn(input int k, input int n, input logic [31:0] data, input logic [31:0] resp);
    for (int i = 0; i < n; i++) begin
      q_mtx.push_back(data[8*i +: 8]);
      resp_q.push_back(resp[8*i +: 8]);
      if (k == 0) q_rx0.push_back(resp[8*i +: 8]);
      else        q_rx1.push_back(resp[8*i +: 8]);
    end
    if (k == 0) q_done0.push_back(1'b1);
    else        q_done1.push_back(1'b1);
  endtask

  // Called at a negedge; drives one requester through a whole transaction.
  task automatic drive_txn(input int k, input int n, input logic [31:0] data, input bit keep);
    int t;
    if (k == 0) begin req_0 = 1'b1; len_0 = 5'(n); end
    else        begin req_1 = 1'b1; len_1 = 5'(n); end
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!rdy_of(k) && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) begin timeout_fail($sformatf("tx_rdy_%0d", k)); return; end
      check($sformatf("gnt_%0d_while_rdy", k), 32'(gnt_of(k)), 32'd1);
      check($sformatf("cs_n_%0d_low_while_rdy", k), 32'(cs_n[k]), 32'd0);
      if (k == 0) begin tx_byte_0 = data[8*i +: 8]; tx_dv_0 = 1'b1; end
      else        begin tx_byte_1 = data[8*i +: 8]; tx_dv_1 = 1'b1; end
      @(negedge clk);
      if (k == 0) tx_dv_0 = 1'b0;
      else        tx_dv_1 = 1'b0;
    end
    t = 0;
    while (!done_of(k) && t < TMO) begin @(negedge clk); t++; end
    if (t >= TMO) begin timeout_fail($sformatf("done_%0d", k)); return; end
    if (!keep) begin
      if (k == 0) req_0 = 1'b0;
      else        req_1 = 1'b0;
    end
  endtask

  // SPI master model: answers each byte three cycles after m_tx_dv.
  initial begin
    m_rx_dv   = 1'b0;
    m_rx_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (m_tx_dv) begin
        repeat (3) @(negedge clk);
        if (resp_q.size() > 0) m_rx_byte = resp_q.pop_front();
        else                   m_rx_byte = 8'h00;
        m_rx_dv = 1'b1;
        @(negedge clk);
        m_rx_dv = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops plus chip-select invariants and gap length.
  initial begin
    int  high_run;
    bit  seen_low;
    high_run = 0;
    seen_low = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (m_tx_dv) begin
          if (q_mtx.size() == 0) begin
            checks++; errors++;
            $display("FAIL m_tx_dv_unexpected: got byte %0h, expected no pulse", m_tx_byte);
          end else check("m_tx_byte", 32'(m_tx_byte), 32'(q_mtx.pop_front()));
        end
        if (rx_dv_0) begin
          if (q_rx0.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_dv_0_unexpected: got byte %0h, expected no pulse", rx_byte);
          end else check("rx_byte_0", 32'(rx_byte), 32'(q_rx0.pop_front()));
        end
        if (rx_dv_1) begin
          if (q_rx1.size() == 0) begin
            checks++; errors++;
            $display("FAIL rx_dv_1_unexpected: got byte %0h, expected no pulse", rx_byte);
          end else check("rx_byte_1", 32'(rx_byte), 32'(q_rx1.pop_front()));
        end
        if (done_0) begin
          checks++;
          if (q_done0.size() == 0) begin
            errors++; $display("FAIL done_0_unexpected: got 1, expected 0");
          end else void'(q_done0.pop_front());
        end
        if (done_1) begin
          checks++;
          if (q_done1.size() == 0) begin
            errors++; $display("FAIL done_1_unexpected: got 1, expected 0");
          end else void'(q_done1.pop_front());
        end
        check("cs_n_both_low", 32'(cs_n == 2'b00), 32'd0);
        check("cs_n0_without_gnt0", 32'(!cs_n[0] && !gnt_0), 32'd0);
        check("cs_n1_without_gnt1", 32'(!cs_n[1] && !gnt_1), 32'd0);
        if (cs_n != 2'b11) cs_low_seen = 1'b1;
        if (rst) begin
          seen_low = 1'b0;
          high_run = 0;
        end else if (cs_n != 2'b11) begin
          if (seen_low && high_run > 0) begin
            checks++;
            if (high_run < CS_GAP) begin
              errors++;
              $display("FAIL cs_gap: high for %0d cycles, expected >= %0d", high_run, CS_GAP);
            end
          end
          seen_low = 1'b1;
          high_run = 0;
        end else begin
          high_run++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1;
    req_0 = 1'b0; req_1 = 1'b0; len_0 = 5'd0; len_1 = 5'd0;
    tx_byte_0 = 8'h00; tx_byte_1 = 8'h00; tx_dv_0 = 1'b0; tx_dv_1 = 1'b0;
    m_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(cs_n), 32'h3);
    check("rst_gnt", 32'({gnt_1, gnt_0}), 32'h0);
    check("rst_done", 32'({done_1, done_0}), 32'h0);
    check("rst_rx_dv", 32'({rx_dv_1, rx_dv_0}), 32'h0);
    check("rst_tx_rdy", 32'({tx_rdy_1, tx_rdy_0}), 32'h0);
    check("rst_m_tx_dv", 32'(m_tx_dv), 32'h0);
    check("rst_m_tx_byte", 32'(m_tx_byte), 32'h0);
    check("rst_rx_byte", 32'(rx_byte), 32'h0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Tie after reset: requester 0 first, then 1; a second tie goes to 0 again.
    expect_txn(0, 2, 32'h0000_2211, 32'h0000_8281);
    expect_txn(1, 2, 32'h0000_4433, 32'h0000_8483);
    fork
      drive_txn(0, 2, 32'h0000_2211, 1'b0);
      drive_txn(1, 2, 32'h0000_4433, 1'b0);
    join
    @(negedge clk);
    expect_txn(0, 1, 32'h0000_0055, 32'h0000_0085);
    expect_txn(1, 1, 32'h0000_0066, 32'h0000_0086);
    fork
      drive_txn(0, 1, 32'h0000_0055, 1'b0);
      drive_txn(1, 1, 32'h0000_0066, 1'b0);
    join
    @(negedge clk);

    // Single write of 40/0A/52.
    expect_txn(0, 3, 32'h0052_0A40, 32'h0003_0201);
    drive_txn(0, 3, 32'h0052_0A40, 1'b0);
    @(negedge clk);

    // Back-to-back with req_0 held between transactions.
    expect_txn(0, 2, 32'h0000_B2B1, 32'h0000_C2C1);
    expect_txn(0, 2, 32'h0000_B4B3, 32'h0000_C4C3);
    drive_txn(0, 2, 32'h0000_B2B1, 1'b1);
    drive_txn(0, 2, 32'h0000_B4B3, 1'b0);
    @(negedge clk);

    // Read on requester 1 ending in A5 while requester 0 pulses tx_dv_0.
    expect_txn(1, 3, 32'h00FF_FFFF, 32'h00A5_7E3C);
    fork
      drive_txn(1, 3, 32'h00FF_FFFF, 1'b0);
      begin
        t = 0;
        while (!gnt_1 && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) timeout_fail("gnt_1_read");
        repeat (6) begin
          check("tx_rdy_0_non_owner", 32'(tx_rdy_0), 32'd0);
          tx_byte_0 = 8'hEE;
          tx_dv_0   = 1'b1;
          @(negedge clk);
          tx_dv_0   = 1'b0;
          @(negedge clk);
        end
      end
    join
    @(negedge clk);

    // Zero-length request: done only, chip select never drops.
    cs_low_seen = 1'b0;
    q_done0.push_back(1'b1);
    drive_txn(0, 0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("len0_cs_never_low", 32'(cs_low_seen), 32'd0);
    check("len0_no_gnt", 32'(gnt_0), 32'd0);

    // Reset after the second byte of a four-byte transaction.
    q_mtx.push_back(8'h71); q_mtx.push_back(8'h72);
    resp_q.push_back(8'h91); resp_q.push_back(8'h92);
    q_rx0.push_back(8'h91); q_rx0.push_back(8'h92);
    req_0 = 1'b1;
    len_0 = 5'd4;
    for (int i = 0; i < 2; i++) begin
      t = 0;
      while (!tx_rdy_0 && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) timeout_fail("tx_rdy_0_rst");
      tx_byte_0 = (i == 0) ? 8'h71 : 8'h72;
      tx_dv_0   = 1'b1;
      @(negedge clk);
      tx_dv_0   = 1'b0;
      t = 0;
      while (!rx_dv_0 && t < TMO) begin @(negedge clk); t++; end
      if (t >= TMO) timeout_fail("rx_dv_0_rst");
    end
    check("pre_rst_cs_n", 32'(cs_n), 32'h2);
    rst   = 1'b1;
    req_0 = 1'b0;
    @(negedge clk);
    check("midxfer_rst_cs_n", 32'(cs_n), 32'h3);
    check("midxfer_rst_gnt", 32'({gnt_1, gnt_0}), 32'h0);
    check("midxfer_rst_tx_rdy", 32'(tx_rdy_0), 32'h0);
    check("midxfer_rst_rx_byte", 32'(rx_byte), 32'h0);
    check("midxfer_rst_m_tx_byte", 32'(m_tx_byte), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Fresh request after reset is served.
    expect_txn(0, 1, 32'h0000_005A, 32'h0000_00C3);
    drive_txn(0, 1, 32'h0000_005A, 1'b0);
    repeat (40) @(negedge clk);

    check("left_m_tx", 32'(q_mtx.size()), 32'd0);
    check("left_rx0", 32'(q_rx0.size()), 32'd0);
    check("left_rx1", 32'(q_rx1.size()), 32'd0);
    check("left_done0", 32'(q_done0.size()), 32'd0);
    check("left_done1", 32'(q_done1.size()), 32'd0);
    check("left_resp", 32'(resp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter CS_SETUP, default 2, meaning clk cycles from cs_n low to first byte offered.
REQ-002 SHALL have parameter CS_GAP, default 31, meaning clk cycles cs_n stays high between transactions.
REQ-003 SHALL have port clk, input, 1, system clock (28 MHz); all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have, for k=0,1, port req_k, input, 1, transaction request; level, held until done_k.
REQ-006 SHALL have, for k=0,1, port len_k, input, 5, transaction byte count; sampled at grant.
REQ-007 SHALL have, for k=0,1, port tx_byte_k, input, 8, byte to send.
REQ-008 SHALL have, for k=0,1, port tx_dv_k, input, 1, one-cycle byte-valid pulse.
REQ-009 SHALL have, for k=0,1, port tx_rdy_k, output, 1, arbiter accepts tx_dv_k this cycle.
REQ-010 SHALL have, for k=0,1, port rx_dv_k, output, 1, one-cycle received-byte pulse.
REQ-011 SHALL have, for k=0,1, port gnt_k, output, 1, requester k owns the bus.
REQ-012 SHALL have, for k=0,1, port done_k, output, 1, one-cycle pulse at transaction end.
REQ-013 SHALL have port rx_byte, output, 8, last received byte, shared by both requesters.
REQ-014 SHALL have port cs_n, output, 2, active-low chip select; bit k for requester k.
REQ-015 SHALL have ports m_tx_byte (output, 8), m_tx_dv (output, 1), m_tx_ready (input, 1), m_rx_dv (input, 1) and m_rx_byte (input, 8), forming the byte interface to the SPI master.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, XFER, GAP.
REQ-017 IDLE: on any req_k, SHALL latch owner and len, assert gnt_owner and drive cs_n[owner] low next cycle, then enter SETUP.
REQ-018 Tie (req_0 & req_1 same cycle): SHALL grant the requester that is not last_owner; last_owner resets to 1, so requester 0 wins the first tie.
REQ-019 len=0 at grant: SHALL skip SETUP/XFER, keep cs_n high, pulse done_owner one cycle later, go to IDLE.
REQ-020 SETUP: SHALL count CS_SETUP cycles, then enter XFER.
REQ-021 XFER: tx_rdy_owner = m_tx_ready & ~pending & (sent < len); non-owner tx_rdy stays 0.
REQ-022 tx_dv_owner & tx_rdy_owner: SHALL register m_tx_byte=tx_byte_owner, pulse m_tx_dv one cycle, increment sent, and set pending.
REQ-023 pending SHALL clear on m_rx_dv; only one byte is ever outstanding at the SPI master.
REQ-024 tx_dv from the non-owner, or any tx_dv while tx_rdy is low, SHALL be ignored with no side effect.
REQ-025 m_rx_dv in XFER: SHALL register rx_byte=m_rx_byte, pulse rx_dv_owner one cycle later, and increment rcvd.
REQ-026 m_rx_dv outside XFER SHALL be dropped, with no rx_dv pulse and rx_byte unchanged.
REQ-027 rcvd==len: SHALL set cs_n all high, deassert gnt, pulse done_owner, set last_owner=owner, and enter GAP, all on the same cycle.
REQ-028 GAP: SHALL hold CS_GAP cycles; no grant is issued; then enter IDLE; a req_k held throughout SHALL be served on the IDLE cycle.
REQ-029 sent and rcvd SHALL be 5 bits, cleared at grant; len=31 SHALL be legal.
REQ-030 At most one cs_n bit SHALL be low at any time, and only when gnt_k is also high.
REQ-031 req_k dropping mid-transaction SHALL NOT abort the transaction; it completes to len.

Reset
REQ-032 rst SHALL take effect on the next clk edge regardless of state, including mid-XFER.
REQ-033 On reset: state=IDLE, cs_n=2'b11, gnt_k=0, done_k=0, rx_dv_k=0, tx_rdy_k=0, m_tx_dv=0, m_tx_byte=0, rx_byte=0, pending=0, sent=0, rcvd=0, last_owner=1.
REQ-034 A transaction cut off by reset SHALL NOT produce done_k; the SPI master is reset by its owner, not by this block.

Verification
REQ-035 Single write: req_0, len=3, bytes 40/0A/52 -> cs_n=10 for the transfer, three m_tx_dv pulses, three rx_dv_0 pulses, done_0, then cs_n=11 held for 31 cycles.
REQ-036 Tie: req_0 and req_1 asserted the same cycle after reset -> gnt_0 first; after the gap gnt_1; a second tie grants 0 again.
REQ-037 Read: req_1, len=3, slave returns xx/xx/A5 -> rx_byte=A5 on the third rx_dv_1 pulse; tx_dv_0 pulsed meanwhile is ignored.
REQ-038 Back-to-back: req_0 held through two transactions -> cs_n high for at least 31 cycles between them.
REQ-039 len=0 -> done pulse, cs_n never low, no m_tx_dv.
REQ-040 rst asserted after the second byte of a len=4 transaction -> next cycle cs_n=11, no done, and a fresh req is accepted afterwards.
